// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous
// input (sig_in) in cycles of clk_in. A new measurement is published with a
// one-cycle valid pulse on every synchronized rising edge of sig_in. If no
// rising edge arrives before the period counter would saturate, the block
// flags stalled, drops back to IDLE and rearms on the next edge.
module clk_period_meter #(
  parameter int WIDTH = 16,
  parameter int SYNC  = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high,
  output logic             valid,
  output logic             stalled
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  // Last count value before the period counter would reach all-ones (MAX).
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           state, state_n;
  logic [SYNC-1:0]  sync_q;
  logic             s;
  logic             s_d;
  logic             rise;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hcnt, hcnt_n;
  logic [WIDTH-1:0] period_n, high_n;
  logic             valid_n, stalled_n;

  // Synchronizer chain plus one delay stage for edge detection.
  // NOTE: non-blocking assignments give every flop the pre-edge value of its
  // neighbour, which is what makes the chain a shift register rather than a wire.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], sig_in};
      s_d    <= sync_q[SYNC-1];
    end
  end

  assign s    = sync_q[SYNC-1];
  assign rise = s & ~s_d;

  // State, counter and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hcnt    <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      stalled <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hcnt    <= hcnt_n;
      period  <= period_n;
      high    <= high_n;
      valid   <= valid_n;
      stalled <= stalled_n;
    end
  end

  // Next-state and next-output logic; a rise that coincides with the timeout
  // still counts as a valid measurement of period MAX.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    hcnt_n    = hcnt;
    period_n  = period;
    high_n    = high;
    valid_n   = 1'b0;
    stalled_n = stalled;

    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = MEASURE;
          cnt_n   = '0;
          hcnt_n  = WIDTH'(1);
        end else begin
          cnt_n   = '0;
          hcnt_n  = '0;
        end
      end

      MEASURE: begin
        if (rise) begin
          period_n  = cnt + WIDTH'(1);
          high_n    = hcnt;
          valid_n   = 1'b1;
          stalled_n = 1'b0;
          cnt_n     = '0;
          hcnt_n    = WIDTH'(1);
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          stalled_n = 1'b1;
          cnt_n     = '0;
          hcnt_n    = '0;
        end else begin
          cnt_n     = cnt + WIDTH'(1);
          hcnt_n    = hcnt + WIDTH'(s);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: WIDTH=8 instance with SYNC=2 checked through a
// scoreboard, plus a SYNC=3 instance on the same input for the latency check.
module tb_clk_period_meter;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] h;
  } exp_t;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period, high, period3, high3;
  logic         valid, stalled, valid3, stalled3;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   armed  = 0;
  int   last_h = 0;
  int   last_l = 0;
  int   cyc    = 0;
  bit   spacing_on = 1'b0;
  int   last_vcyc  = -1;

  clk_period_meter #(.WIDTH(W), .SYNC(2)) u_dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .period (period),
    .high   (high),
    .valid  (valid),
    .stalled(stalled)
  );

  clk_period_meter #(.WIDTH(W), .SYNC(3)) u_dut3 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .period (period3),
    .high   (high3),
    .valid  (valid3),
    .stalled(stalled3)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard monitor: every valid pops one expected measurement.
  always @(negedge clk_in) begin
    if (rst_n) begin
      total++;
      if ($isunknown({valid, stalled})) begin
        bad++;
        $display("FAIL no_x: got valid=%b stalled=%b want known values", valid, stalled);
      end
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got period=%0d high=%0d want no valid", period, high);
        end else begin
          mon_e = sb.pop_front();
          total++;
          if (period !== mon_e.p) begin
            bad++;
            $display("FAIL period: got %0d want %0d", period, mon_e.p);
          end
          total++;
          if (high !== mon_e.h) begin
            bad++;
            $display("FAIL high: got %0d want %0d", high, mon_e.h);
          end
          total++;
          if (stalled !== 1'b0) begin
            bad++;
            $display("FAIL stalled_at_valid: got %b want 0", stalled);
          end
          if (spacing_on) begin
            if (last_vcyc >= 0) begin
              total++;
              if (cyc - last_vcyc != int'(mon_e.p)) begin
                bad++;
                $display("FAIL valid_spacing: got %0d want %0d", cyc - last_vcyc, mon_e.p);
              end
            end
            last_vcyc = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Model of one rising edge: it reports the previous full period unless
  // the block is unarmed or that period exceeded MAX (stall, rearm only).
  task automatic model_rise(input int h, input int l);
    exp_t e;
    if (armed != 0 && last_h + last_l <= MAXV) begin
      e.p = W'(last_h + last_l);
      e.h = W'(last_h);
      sb.push_back(e);
    end
    armed  = 1;
    last_h = h;
    last_l = l;
  endtask

  task automatic drive_pulse(input int h, input int l);
    model_rise(h, l);
    sig_in = 1'b1;
    repeat (h) tick();
    sig_in = 1'b0;
    repeat (l) tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sig_in = 1'b0;
    tick();
    tick();
    total++;
    if (period !== '0) begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
    total++;
    if (high !== '0) begin bad++; $display("FAIL reset_high: got %0d want 0", high); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++;
    if (stalled !== 1'b0) begin bad++; $display("FAIL reset_stalled: got %b want 0", stalled); end
    rst_n = 1'b1;
    armed = 0;
    tick();
  endtask

  task automatic test_basic();
    spacing_on = 1'b1;
    last_vcyc  = -1;
    for (int i = 0; i < 8; i++) drive_pulse(2, 2);
    spacing_on = 1'b0;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL basic_drained: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_duty();
    for (int i = 0; i < 5; i++) drive_pulse(3, 7);
    for (int i = 0; i < 5; i++) drive_pulse(7, 3);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL duty_drained: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_boundary_stall();
    drive_pulse(5, 250);
    drive_pulse(5, 250);
    // One period of 256 cycles: must time out with no measurement.
    model_rise(3, 253);
    sig_in = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 3) sig_in = 1'b0;
      if (i == 250) begin
        total++;
        if (stalled !== 1'b0) begin bad++; $display("FAIL stall_early: got %b want 0", stalled); end
      end
    end
    drive_pulse(3, 3);
    total++;
    if (stalled !== 1'b1) begin bad++; $display("FAIL stall_set: got %b want 1", stalled); end
    drive_pulse(3, 3);
    drive_pulse(3, 3);
    total++;
    if (stalled !== 1'b0) begin bad++; $display("FAIL stall_cleared: got %b want 0", stalled); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL stall_drained: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    drive_pulse(4, 4);
    drive_pulse(4, 2);
    #2;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    total++;
    if (period !== '0) begin bad++; $display("FAIL async_period: got %0d want 0", period); end
    total++;
    if (high !== '0) begin bad++; $display("FAIL async_high: got %0d want 0", high); end
    total++;
    if ({valid, stalled} !== 2'b00) begin bad++; $display("FAIL async_flags: got %b want 00", {valid, stalled}); end
    tick();
    tick();
    rst_n = 1'b1;
    armed = 0;
    tick();
    drive_pulse(4, 4);
    drive_pulse(4, 4);
    drive_pulse(5, 5);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset_drained: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 6; i++) drive_pulse(1, 19);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL glitch_drained: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_latency();
    logic v2, v3;
    drive_pulse(3, 3);
    drive_pulse(3, 3);
    model_rise(3, 3);
    sig_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) sig_in = 1'b0;
      v2 = valid;
      v3 = valid3;
      total++;
      if (v2 !== (i == 2)) begin bad++; $display("FAIL latency_sync2 edge+%0d: got %b want %b", i, v2, (i == 2)); end
      total++;
      if (v3 !== (i == 3)) begin bad++; $display("FAIL latency_sync3 edge+%0d: got %b want %b", i, v3, (i == 3)); end
      if (i == 3) begin
        total++;
        if ({period3, high3, stalled3} !== {W'(6), W'(3), 1'b0}) begin
          bad++;
          $display("FAIL sync3_result: got period=%0d high=%0d stalled=%b want 6 3 0", period3, high3, stalled3);
        end
      end
    end
    last_l = last_l + 0;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL latency_drained: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty();
    test_boundary_stall();
    test_reset_mid();
    test_glitch();
    test_latency();
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
